// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, functs,
// ALU operations, mux selects and the controller state encoding.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1100;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_SEXT = 2'd1;
  localparam logic [1:0] SRCB_ZEXT = 2'd2;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_R  = 4'd2,
    S_EXE_I  = 4'd3,
    S_EXE_LS = 4'd4,
    S_EXE_BR = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_HALT   = 4'd10,
    S_FAULT  = 4'd11
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct decode into an ALU operation, flagging any
// opcode or R-type funct the controller does not implement.
module alu_op_decode
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal
);

  always_comb begin
    alu_op  = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_op = ALUOP_W'(ALU_ADD);
          F_SUB:   alu_op = ALUOP_W'(ALU_SUB);
          F_AND:   alu_op = ALUOP_W'(ALU_AND);
          F_OR:    alu_op = ALUOP_W'(ALU_OR);
          F_SLT:   alu_op = ALUOP_W'(ALU_SLT);
          F_SLL:   alu_op = ALUOP_W'(ALU_SLL);
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_op = ALUOP_W'(ALU_ADD);
      OP_ANDI:               alu_op = ALUOP_W'(ALU_AND);
      OP_ORI:                alu_op = ALUOP_W'(ALU_OR);
      // bgtz also subtracts so that Zero/Sign describe rs against 0
      OP_BEQ, OP_BGTZ:       alu_op = ALUOP_W'(ALU_SUB);
      OP_J, OP_HALT:         alu_op = '0;
      default:               illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Per-phase control FSM for the multi-cycle MIPS-subset datapath, with a
// memory-ready watchdog and traps on illegal instructions.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int INSTR_W      = 32,
  parameter int ALUOP_W      = 4,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instruct,
  input  logic               Zero,
  input  logic               Sign,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               Halted,
  output logic               Fault,
  output logic [3:0]         State
);

  state_t state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic [5:0] opcode, funct;
  logic [ALUOP_W-1:0] dec_alu_op;
  logic dec_illegal, is_wait, mem_timeout, unused_fields;

  assign opcode        = Instruct[INSTR_W-1 -: 6];
  assign funct         = Instruct[5:0];
  assign unused_fields = ^Instruct[INSTR_W-7:6];
  assign State         = state;

  alu_op_decode #(.ALUOP_W(ALUOP_W)) u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  assign is_wait     = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign mem_timeout = is_wait && !MemReady && (wait_cnt == 8'(MEM_WAIT_MAX - 1));

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state    <= S_IF;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Any state change clears the count, so every wait state starts from zero
  always_comb begin
    wait_cnt_next = '0;
    if (is_wait && (state_next == state))
      wait_cnt_next = wait_cnt + 8'd1;
  end

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    PCSrc      = PC_SEQ;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    ALUOp      = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    Halted     = 1'b0;
    Fault      = 1'b0;
    // Holding outputs low while Reset is asserted aborts any in-flight write
    if (Reset) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            state_next = S_ID;
          end else if (mem_timeout) begin
            state_next = S_FAULT;
          end
        end
        S_ID: begin
          if (dec_illegal) begin
            state_next = S_FAULT;
          end else begin
            case (opcode)
              OP_RTYPE:                 state_next = S_EXE_R;
              OP_ADDI, OP_ANDI, OP_ORI: state_next = S_EXE_I;
              OP_LW, OP_SW:             state_next = S_EXE_LS;
              OP_BEQ, OP_BGTZ:          state_next = S_EXE_BR;
              OP_HALT:                  state_next = S_HALT;
              OP_J: begin
                PCWrite    = 1'b1;
                PCSrc      = PC_JUMP;
                state_next = S_IF;
              end
              default:                  state_next = S_FAULT;
            endcase
          end
        end
        S_EXE_R: begin
          ALUOp      = dec_alu_op;
          ALUSrcA    = (funct == F_SLL);
          state_next = S_WB_ALU;
        end
        S_EXE_I: begin
          ALUOp      = dec_alu_op;
          ALUSrcB    = (opcode == OP_ADDI) ? SRCB_SEXT : SRCB_ZEXT;
          state_next = S_WB_ALU;
        end
        S_EXE_LS: begin
          ALUOp      = ALUOP_W'(ALU_ADD);
          ALUSrcB    = SRCB_SEXT;
          state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_EXE_BR: begin
          ALUOp = ALUOP_W'(ALU_SUB);
          if (((opcode == OP_BEQ) && Zero) || ((opcode == OP_BGTZ) && !Zero && !Sign)) begin
            PCWrite = 1'b1;
            PCSrc   = PC_BRANCH;
          end
          state_next = S_IF;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          if (MemReady)         state_next = S_WB_MEM;
          else if (mem_timeout) state_next = S_FAULT;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          if (MemReady)         state_next = S_IF;
          else if (mem_timeout) state_next = S_FAULT;
        end
        S_WB_ALU: begin
          RegWrite   = 1'b1;
          RegDst     = (opcode == OP_RTYPE);
          state_next = S_IF;
        end
        S_WB_MEM: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          state_next = S_IF;
        end
        S_HALT: begin
          Halted = 1'b1;
        end
        S_FAULT: begin
          Halted = 1'b1;
          Fault  = 1'b1;
        end
        default: state_next = S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes its
// expected output vector, which the negedge monitor pops and compares.
module tb_multicycle_control;
  import ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       rw;
    logic       rdst;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       hlt;
    logic       flt;
  } vec_t;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLL = 4'b1100;

  localparam logic [31:0] I_ADD  = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000};
  localparam logic [31:0] I_SLL  = {6'b000000, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000000};
  localparam logic [31:0] I_ADDI = {6'b001000, 5'd1, 5'd2, 16'h0005};
  localparam logic [31:0] I_ORI  = {6'b001101, 5'd1, 5'd2, 16'h00f0};
  localparam logic [31:0] I_LW   = {6'b100011, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_SW   = {6'b101011, 5'd1, 5'd2, 16'h0014};
  localparam logic [31:0] I_BEQ  = {6'b000100, 5'd1, 5'd2, 16'h0003};
  localparam logic [31:0] I_BGTZ = {6'b000111, 5'd1, 5'd0, 16'h0003};
  localparam logic [31:0] I_J    = {6'b000010, 26'h0000040};
  localparam logic [31:0] I_HALT = {6'b111111, 26'h0};
  localparam logic [31:0] I_BAD  = {6'b010101, 26'h0};

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] Instruct;
  logic        Zero, Sign, MemReady;
  logic        PCWrite, IRWrite, RegWrite, RegDst, ALUSrcA;
  logic        MemRead, MemWrite, MemToReg, Halted, Fault;
  logic [1:0]  PCSrc, ALUSrcB;
  logic [3:0]  ALUOp, State;

  vec_t  exp_q[$];
  string tag_q[$];
  vec_t  mon_exp, mon_act;
  string mon_tag;
  int    checks = 0;
  int    errors = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.INSTR_W(32), .ALUOP_W(4), .MEM_WAIT_MAX(4)) dut (
    .CLK(CLK), .Reset(Reset), .Instruct(Instruct), .Zero(Zero), .Sign(Sign),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .Halted(Halted), .Fault(Fault), .State(State)
  );

  task automatic checkOutput(input string tag, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", tag, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {State, PCWrite, PCSrc, IRWrite, RegWrite, RegDst, ALUSrcA,
                 ALUSrcB, ALUOp, MemRead, MemWrite, MemToReg, Halted, Fault};
      checkOutput(mon_tag, mon_act, mon_exp);
    end
  end

  function automatic vec_t v(input state_t st);
    vec_t r;
    r    = '0;
    r.st = st;
    return r;
  endfunction

  task automatic applyStimulus(input logic rst_n, input logic [31:0] ins, input logic z,
                               input logic s, input logic rdy, input vec_t e, input string tag);
    Reset    = rst_n;
    Instruct = ins;
    Zero     = z;
    Sign     = s;
    MemReady = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic [31:0] ins, input logic rdy, input vec_t e, input string tag);
    applyStimulus(1'b1, ins, 1'b0, 1'b0, rdy, e, tag);
  endtask

  task automatic fetch(input logic [31:0] ins, input string tag);
    vec_t e;
    e = v(S_IF); e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    step(ins, 1'b1, e, {tag, " IF"});
    e = v(S_ID);
    if (ins == I_J) begin e.pcw = 1'b1; e.pcsrc = 2'd2; end
    step(ins, 1'b1, e, {tag, " ID"});
  endtask

  task automatic resetCycle();
    Reset    = 1'b0;
    MemReady = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic branch(input logic [31:0] ins, input logic z, input logic s,
                        input logic taken, input string tag);
    vec_t e;
    fetch(ins, tag);
    e = v(S_EXE_BR); e.aluop = A_SUB;
    if (taken) begin e.pcw = 1'b1; e.pcsrc = 2'd1; end
    applyStimulus(1'b1, ins, z, s, 1'b1, e, {tag, " EXE"});
  endtask

  task automatic aluInstr(input logic [31:0] ins, input state_t exe, input logic [3:0] op,
                          input logic srca, input logic [1:0] srcb, input logic rdst,
                          input string tag);
    vec_t e;
    fetch(ins, tag);
    e = v(exe); e.aluop = op; e.srca = srca; e.srcb = srcb;
    step(ins, 1'b1, e, {tag, " EXE"});
    e = v(S_WB_ALU); e.rw = 1'b1; e.rdst = rdst;
    step(ins, 1'b1, e, {tag, " WB"});
  endtask

  initial begin : main
    vec_t e;
    Reset = 1'b0; Instruct = '0; Zero = 1'b0; Sign = 1'b0; MemReady = 1'b0;
    @(posedge CLK);
    #1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, v(S_IF), "reset");

    aluInstr(I_ADD,  S_EXE_R, A_ADD, 1'b0, 2'd0, 1'b1, "add");
    aluInstr(I_SLL,  S_EXE_R, A_SLL, 1'b1, 2'd0, 1'b1, "sll");
    aluInstr(I_ADDI, S_EXE_I, A_ADD, 1'b0, 2'd1, 1'b0, "addi");
    aluInstr(I_ORI,  S_EXE_I, A_OR,  1'b0, 2'd2, 1'b0, "ori");

    // lw with three wait cycles in MEM_RD
    fetch(I_LW, "lw");
    e = v(S_EXE_LS); e.aluop = A_ADD; e.srcb = 2'd1;
    step(I_LW, 1'b1, e, "lw EXE");
    e = v(S_MEM_RD); e.mrd = 1'b1;
    for (int i = 0; i < 3; i++) step(I_LW, 1'b0, e, $sformatf("lw wait%0d", i));
    step(I_LW, 1'b1, e, "lw MEM");
    e = v(S_WB_MEM); e.rw = 1'b1; e.m2r = 1'b1;
    step(I_LW, 1'b1, e, "lw WB");

    fetch(I_SW, "sw");
    e = v(S_EXE_LS); e.aluop = A_ADD; e.srcb = 2'd1;
    step(I_SW, 1'b1, e, "sw EXE");
    e = v(S_MEM_WR); e.mwr = 1'b1;
    step(I_SW, 1'b1, e, "sw MEM");

    branch(I_BEQ,  1'b1, 1'b0, 1'b1, "beq z1");
    branch(I_BEQ,  1'b0, 1'b0, 1'b0, "beq z0");
    branch(I_BGTZ, 1'b0, 1'b1, 1'b0, "bgtz neg");
    branch(I_BGTZ, 1'b0, 1'b0, 1'b1, "bgtz pos");
    branch(I_BGTZ, 1'b1, 1'b0, 1'b0, "bgtz zero");

    fetch(I_J, "j");

    // MemReady arriving on the last allowed wait cycle still fetches
    e = v(S_IF); e.mrd = 1'b1;
    for (int i = 0; i < 3; i++) step(I_J, 1'b0, e, $sformatf("ifwait%0d", i));
    fetch(I_J, "ifwait ready");

    // Reset during WB_MEM must suppress RegWrite in that cycle
    fetch(I_LW, "lwrst");
    e = v(S_EXE_LS); e.aluop = A_ADD; e.srcb = 2'd1;
    step(I_LW, 1'b1, e, "lwrst EXE");
    e = v(S_MEM_RD); e.mrd = 1'b1;
    step(I_LW, 1'b1, e, "lwrst MEM");
    applyStimulus(1'b0, I_LW, 1'b0, 1'b0, 1'b1, v(S_WB_MEM), "lwrst reset");
    e = v(S_IF); e.mrd = 1'b1;
    step(I_HALT, 1'b0, e, "after reset");

    fetch(I_HALT, "halt");
    e = v(S_HALT); e.hlt = 1'b1;
    for (int i = 0; i < 2; i++) step(I_HALT, 1'b1, e, $sformatf("halt hold%0d", i));
    resetCycle();

    fetch(I_BAD, "badop");
    e = v(S_FAULT); e.hlt = 1'b1; e.flt = 1'b1;
    for (int i = 0; i < 2; i++) step(I_BAD, 1'b1, e, $sformatf("badop hold%0d", i));
    resetCycle();

    // Watchdog expiry in IF after four idle cycles
    e = v(S_IF); e.mrd = 1'b1;
    for (int i = 0; i < 4; i++) step(I_ADD, 1'b0, e, $sformatf("wdog wait%0d", i));
    e = v(S_FAULT); e.hlt = 1'b1; e.flt = 1'b1;
    step(I_ADD, 1'b0, e, "wdog fault");
    step(I_ADD, 1'b1, e, "wdog hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
